sig_menu_ctrl: RTL and testbench

Front-panel control stage directly upstream of the waveform generator. Debounces four raw push-buttons and runs a menu FSM that edits four 2-bit setting selectors: waveform, amplitude, frequency, phase/duty. Drives the generator's cnt_sig/cnt_amp/cnt_fre/cnt_phase/confirm inputs. Drives one-hot LEDs showing the field being edited.

---
 rtl/sig_pkg.sv | 33 +++
 rtl/sig_menu_ctrl_if.sv | 24 ++
 rtl/key_debounce.sv | 72 +++++++
 rtl/sig_menu_ctrl.sv | 87 ++++++++
 tb/tb_sig_menu_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sig_pkg.sv
// Shared definitions for the front-panel menu controller and the waveform
// generator: key indices, field encodings, FSM state type and the field LED
// decoder.
package sig_pkg;

  localparam int KEY_SEL  = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_OK   = 3;

  localparam logic [1:0] FLD_SIG = 2'd0;
  localparam logic [1:0] FLD_AMP = 2'd1;
  localparam logic [1:0] FLD_FRE = 2'd2;
  localparam logic [1:0] FLD_PHA = 2'd3;

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One-hot LED pattern for the field being edited; dark while running.
  function automatic logic [3:0] field_onehot(input logic [1:0] fld, input state_e st);
    logic [3:0] oh;
    oh = 4'b0000;
    if (st == ST_EDIT) begin
      oh[fld] = 1'b1;
    end else begin
      oh = 4'b0000;
    end
    return oh;
  endfunction

endpackage

// File: rtl/sig_menu_ctrl_if.sv
// Bundle between the front panel, the menu controller and the generator.
// The controller (master) consumes the raw keys and drives the settings;
// the generator (slave) only observes the settings.
interface sig_menu_ctrl_if;

  logic [3:0] key_n;
  logic [1:0] cnt_sig;
  logic [1:0] cnt_amp;
  logic [1:0] cnt_fre;
  logic [1:0] cnt_phase;
  logic       confirm;
  logic [3:0] field_oh;
  logic       key_evt;

  modport master (
    input  key_n,
    output cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, field_oh, key_evt
  );

  modport slave (
    input  cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, field_oh, key_evt
  );

endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle press pulse on the debounced 1->0 edge.
// After reset the key is disarmed until it has been seen released for
// DEB_CYCLES cycles, so a button held through reset is never reported.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic prs
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prs_q, prs_d;

  // Debounce counter, debounced level, arming and press detection.
  always_comb begin
    deb_d   = deb_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    prs_d   = 1'b0;
    if (!armed_q) begin
      // Count consecutive released cycles before accepting any press.
      if (!sync2_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        armed_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = ~deb_q;
      cnt_d = '0;
      prs_d = deb_q;  // only the released->pressed edge is a press
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous active-low reset to the released level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      prs_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      prs_q   <= prs_d;
    end
  end

  assign prs = prs_q;

endmodule

// File: rtl/sig_menu_ctrl.sv
// Front-panel menu controller: debounces four buttons and edits the four
// 2-bit generator settings in EDIT mode; OK toggles between EDIT and RUN,
// and RUN locks the settings.
module sig_menu_ctrl
  import sig_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  sig_menu_ctrl_if.master bus
);

  logic [3:0]      prs;
  state_e          state_q, state_d;
  logic [1:0]      field_q, field_d;
  logic [3:0][1:0] set_q, set_d;
  logic [3:0]      field_oh_q, field_oh_d;
  logic            key_evt_q, key_evt_d;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key_n[g]),
      .prs   (prs[g])
    );
  end

  // Menu FSM: one action per cycle, priority OK > SEL > UP > DOWN.
  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    set_d     = set_q;
    key_evt_d = |prs;
    if (prs[KEY_OK]) begin
      case (state_q)
        ST_EDIT: state_d = ST_RUN;
        ST_RUN:  state_d = ST_EDIT;
        default: state_d = ST_EDIT;
      endcase
    end else if (state_q == ST_RUN) begin
      state_d = ST_RUN;  // settings locked while running
    end else if (prs[KEY_SEL]) begin
      field_d = field_q + 2'd1;
    end else if (prs[KEY_UP] && prs[KEY_DOWN]) begin
      set_d = set_q;  // conflicting request, ignore
    end else if (prs[KEY_UP]) begin
      set_d[field_q] = set_q[field_q] + 2'd1;
    end else if (prs[KEY_DOWN]) begin
      set_d[field_q] = set_q[field_q] - 2'd1;
    end else begin
      set_d = set_q;
    end
    field_oh_d = field_onehot(field_d, state_d);
  end

  // Registered menu state and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EDIT;
      field_q    <= FLD_SIG;
      set_q      <= '0;
      field_oh_q <= 4'b0001;
      key_evt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      set_q      <= set_d;
      field_oh_q <= field_oh_d;
      key_evt_q  <= key_evt_d;
    end
  end

  assign bus.cnt_sig   = set_q[FLD_SIG];
  assign bus.cnt_amp   = set_q[FLD_AMP];
  assign bus.cnt_fre   = set_q[FLD_FRE];
  assign bus.cnt_phase = set_q[FLD_PHA];
  assign bus.confirm   = (state_q == ST_RUN);
  assign bus.field_oh  = field_oh_q;
  assign bus.key_evt   = key_evt_q;

endmodule

// File: tb/tb_sig_menu_ctrl.sv
// Directed bench for sig_menu_ctrl with DEB_CYCLES=4.
module tb_sig_menu_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   n_evt;
  int   evt_base;

  sig_menu_ctrl_if bus ();

  sig_menu_ctrl #(
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.key_evt === 1'b1) n_evt++;
    end
  endtask

  // Press the keys in mask (bit set = pressed), hold, release, settle.
  task automatic press(input logic [3:0] mask);
    bus.key_n = ~mask;
    tick(8);
    bus.key_n = 4'hF;
    tick(10);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_evt = 0;
    rst_n = 1'b0;
    bus.key_n = 4'hF;

    // Reset values
    tick(3);
    chk_val("rst_cnt", {bus.cnt_sig, bus.cnt_amp, bus.cnt_fre, bus.cnt_phase}, 8'h00);
    chk_val("rst_confirm", 8'(bus.confirm), 8'd0);
    chk_val("rst_field_oh", 8'(bus.field_oh), 8'h01);
    chk_val("rst_key_evt", 8'(bus.key_evt), 8'd0);
    rst_n = 1'b1;
    tick(10);

    // Bouncing UP never reaches 4 stable cycles
    evt_base = n_evt;
    bus.key_n = 4'b1101; tick(3);
    bus.key_n = 4'b1111; tick(1);
    bus.key_n = 4'b1101; tick(2);
    bus.key_n = 4'b1111; tick(12);
    chk_val("bounce_cnt_sig", 8'(bus.cnt_sig), 8'd0);
    chk_val("bounce_evt", 8'(n_evt - evt_base), 8'd0);

    // Clean UP: 2 sync + 4 debounce + 1 register edges
    evt_base = n_evt;
    bus.key_n = 4'b1101;
    tick(6);
    chk_val("up_early_cnt", 8'(bus.cnt_sig), 8'd0);
    chk_val("up_early_evt", 8'(bus.key_evt), 8'd0);
    tick(1);
    chk_val("up_edge_cnt", 8'(bus.cnt_sig), 8'd1);
    chk_val("up_edge_evt", 8'(bus.key_evt), 8'd1);
    tick(1);
    chk_val("up_evt_pulse", 8'(bus.key_evt), 8'd0);
    tick(2);
    bus.key_n = 4'hF;
    tick(10);
    chk_val("up_hold_cnt", 8'(bus.cnt_sig), 8'd1);
    chk_val("up_hold_evts", 8'(n_evt - evt_base), 8'd1);

    // Field select and DOWN wrap
    press(4'b0001);
    press(4'b0001);
    chk_val("sel2_field_oh", 8'(bus.field_oh), 8'h04);
    press(4'b0100);
    chk_val("down_wrap_fre", 8'(bus.cnt_fre), 8'd3);
    for (int i = 0; i < 4; i++) press(4'b0001);
    chk_val("sel4_wrap_field_oh", 8'(bus.field_oh), 8'h04);
    for (int i = 0; i < 3; i++) press(4'b0001);
    chk_val("sel_amp_field_oh", 8'(bus.field_oh), 8'h02);
    press(4'b0010);
    press(4'b0010);
    chk_val("amp_up2", 8'(bus.cnt_amp), 8'd2);
    press(4'b0010);
    press(4'b0010);
    chk_val("amp_up4_wrap", 8'(bus.cnt_amp), 8'd0);

    // Run lock
    press(4'b1000);
    chk_val("run_confirm", 8'(bus.confirm), 8'd1);
    chk_val("run_field_oh", 8'(bus.field_oh), 8'h00);
    evt_base = n_evt;
    press(4'b0010);
    press(4'b0001);
    chk_val("run_lock_cnt", {bus.cnt_sig, bus.cnt_amp, bus.cnt_fre, bus.cnt_phase}, 8'h4C);
    chk_val("run_lock_evts", 8'(n_evt - evt_base), 8'd2);
    chk_val("run_lock_field_oh", 8'(bus.field_oh), 8'h00);
    press(4'b1000);
    chk_val("edit_confirm", 8'(bus.confirm), 8'd0);
    chk_val("edit_field_oh", 8'(bus.field_oh), 8'h02);

    // Simultaneous presses
    evt_base = n_evt;
    press(4'b0110);
    chk_val("updown_cnt", {bus.cnt_sig, bus.cnt_amp, bus.cnt_fre, bus.cnt_phase}, 8'h4C);
    chk_val("updown_evts", 8'(n_evt - evt_base), 8'd1);
    press(4'b1010);
    chk_val("okup_confirm", 8'(bus.confirm), 8'd1);
    chk_val("okup_cnt", {bus.cnt_sig, bus.cnt_amp, bus.cnt_fre, bus.cnt_phase}, 8'h4C);
    press(4'b1000);
    chk_val("okup_back_confirm", 8'(bus.confirm), 8'd0);

    // Reset while UP is mid-debounce, key still held afterwards
    bus.key_n = 4'b1101;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    evt_base = n_evt;
    tick(12);
    chk_val("rstmid_cnt_sig", 8'(bus.cnt_sig), 8'd0);
    chk_val("rstmid_evts", 8'(n_evt - evt_base), 8'd0);
    bus.key_n = 4'hF;
    tick(10);
    chk_val("rstmid_idle_cnt_sig", 8'(bus.cnt_sig), 8'd0);
    press(4'b0010);
    chk_val("rstmid_repress_cnt_sig", 8'(bus.cnt_sig), 8'd1);
    chk_val("rstmid_repress_evts", 8'(n_evt - evt_base), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
